// File: rtl/indexed_sprite_ram_if.sv
// Bus bundle for indexed_sprite_ram: pixel writes, pipelined reads, palette writes and fill control.
// pal_wbank/pal_swap exist only when PALETTE_BANK_EN is defined.
interface indexed_sprite_ram_if #(
  parameter int ADDR_W = 19,
  parameter int IDX_W  = 8
);
  logic              pix_we;
  logic [ADDR_W-1:0] pix_waddr;
  logic [IDX_W-1:0]  pix_wdata;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [23:0]       rd_rgb;
  logic              rd_transparent;
  logic              pal_we;
  logic [IDX_W-1:0]  pal_waddr;
  logic [23:0]       pal_wdata;
  logic              fill_start;
  logic [IDX_W-1:0]  fill_idx;
  logic              busy;
`ifdef PALETTE_BANK_EN
  logic              pal_wbank;
  logic              pal_swap;

  modport master (
    output pix_we, pix_waddr, pix_wdata, rd_req, rd_addr, pal_we, pal_waddr, pal_wdata,
           fill_start, fill_idx, pal_wbank, pal_swap,
    input  rd_valid, rd_rgb, rd_transparent, busy
  );
  modport slave (
    input  pix_we, pix_waddr, pix_wdata, rd_req, rd_addr, pal_we, pal_waddr, pal_wdata,
           fill_start, fill_idx, pal_wbank, pal_swap,
    output rd_valid, rd_rgb, rd_transparent, busy
  );
`else
  modport master (
    output pix_we, pix_waddr, pix_wdata, rd_req, rd_addr, pal_we, pal_waddr, pal_wdata,
           fill_start, fill_idx,
    input  rd_valid, rd_rgb, rd_transparent, busy
  );
  modport slave (
    input  pix_we, pix_waddr, pix_wdata, rd_req, rd_addr, pal_we, pal_waddr, pal_wdata,
           fill_start, fill_idx,
    output rd_valid, rd_rgb, rd_transparent, busy
  );
`endif
endinterface

// File: rtl/indexed_sprite_ram.sv
// Palette-indexed pixel store: 2-stage pipelined read (index, then palette), runtime palette, fill sweep.
// Define PALETTE_BANK_EN for two palette banks with pal_wbank write-select and pal_swap toggle.
module indexed_sprite_ram #(
  parameter int              DEPTH       = 30352,
  parameter int              ADDR_W      = 19,
  parameter int              IDX_W       = 8,
  parameter int              PAL_ENTRIES = 70,
  parameter logic [IDX_W-1:0] TRANS_IDX  = IDX_W'(8'h45),
  parameter logic [23:0]     DEFAULT_RGB = 24'hFF00FF,
  parameter                  INIT_FILE   = "",
  parameter                  PAL_FILE    = ""
) (
  input logic Clk,
  input logic Reset,
  indexed_sprite_ram_if.slave bus
);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PAL_AW = (PAL_ENTRIES > 1) ? $clog2(PAL_ENTRIES) : 1;
`ifdef PALETTE_BANK_EN
  localparam int NBANK = 2;
`else
  localparam int NBANK = 1;
`endif
  localparam int PALF    = NBANK * PAL_ENTRIES;
  localparam int PALF_AW = (PALF > 1) ? $clog2(PALF) : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]  r_fill_idx, w_fill_idx_nxt;
  logic              w_busy, w_fill_we;

  logic [IDX_W-1:0]  r_mem [DEPTH];
  logic [23:0]       r_pal [PALF];

  logic              w_mem_we, w_rd_ok, w_pal_wok, w_pal_hit;
  logic [MEM_AW-1:0] w_mem_waddr;
  logic [IDX_W-1:0]  w_mem_wdata;
  logic [PALF_AW-1:0] w_pal_ridx, w_pal_widx;
  logic              w_rbank, w_wbank;

  logic [IDX_W-1:0]  r_s1_idx;
  logic              r_s1_valid, r_s1_oor;
  logic              r_rd_valid, r_rd_trans;
  logic [23:0]       r_rd_rgb;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_fill_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_fill_idx <= w_fill_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_fill_idx_nxt = r_fill_idx;
    w_busy         = 1'b0;
    w_fill_we      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.fill_start) begin
          w_state_nxt    = S_FILL;
          w_cnt_nxt      = '0;
          w_fill_idx_nxt = bus.fill_idx;
        end
      end
      S_FILL: begin
        w_busy    = 1'b1;
        w_fill_we = 1'b1;
        if (r_cnt == ADDR_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
        else                             w_cnt_nxt   = r_cnt + 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The sweep owns the single write port; host pixel writes are dropped while busy.
  assign w_mem_we    = w_fill_we |
                       (bus.pix_we && !w_busy && (32'(bus.pix_waddr) < 32'(DEPTH)));
  assign w_mem_waddr = w_fill_we ? r_cnt[MEM_AW-1:0] : bus.pix_waddr[MEM_AW-1:0];
  assign w_mem_wdata = w_fill_we ? r_fill_idx : bus.pix_wdata;
  assign w_rd_ok     = 32'(bus.rd_addr) < 32'(DEPTH);

  always_ff @(posedge Clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    if (bus.rd_req && w_rd_ok) r_s1_idx <= r_mem[bus.rd_addr[MEM_AW-1:0]];
  end

`ifdef PALETTE_BANK_EN
  logic r_bank;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)             r_bank <= 1'b0;
    else if (bus.pal_swap) r_bank <= ~r_bank;
  end
  assign w_rbank = r_bank;
  assign w_wbank = bus.pal_wbank;
`else
  assign w_rbank = 1'b0;
  assign w_wbank = 1'b0;
`endif

  // Banks are stacked in one flat array: bank b occupies [b*PAL_ENTRIES +: PAL_ENTRIES].
  assign w_pal_wok  = 32'(bus.pal_waddr) < 32'(PAL_ENTRIES);
  assign w_pal_widx = PALF_AW'(w_wbank ? PAL_ENTRIES : 0) + PALF_AW'(bus.pal_waddr[PAL_AW-1:0]);
  assign w_pal_ridx = PALF_AW'(w_rbank ? PAL_ENTRIES : 0) + PALF_AW'(r_s1_idx[PAL_AW-1:0]);
  assign w_pal_hit  = !r_s1_oor && (32'(r_s1_idx) < 32'(PAL_ENTRIES));

  always_ff @(posedge Clk) begin
    if (bus.pal_we && w_pal_wok) r_pal[w_pal_widx] <= bus.pal_wdata;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_s1_valid <= 1'b0;
      r_s1_oor   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_rgb   <= '0;
      r_rd_trans <= 1'b0;
    end else begin
      r_s1_valid <= bus.rd_req;
      if (bus.rd_req) r_s1_oor <= !w_rd_ok;
      r_rd_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_rd_rgb   <= w_pal_hit ? r_pal[w_pal_ridx] : DEFAULT_RGB;
        r_rd_trans <= !r_s1_oor && (r_s1_idx == TRANS_IDX);
      end
    end
  end

  assign bus.rd_valid       = r_rd_valid;
  assign bus.rd_rgb         = r_rd_rgb;
  assign bus.rd_transparent = r_rd_trans;
  assign bus.busy           = w_busy;
endmodule
